// File: rtl/supermic_pkg.sv
// Shared defaults and width helpers for the PDM delay-and-sum beamformer.
package supermic_pkg;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_MAX_DELAY = 32;
  localparam int unsigned DEF_DECIM     = 32;
  localparam int unsigned DEF_CIC_ORDER = 3;
  localparam int unsigned DEF_OUT_W     = 16;

  // Signed width holding the sum of num_ch values of +/-1.
  function automatic int unsigned in_width(input int unsigned num_ch);
    return $clog2(num_ch) + 2;
  endfunction

  // CIC register growth: DECIM^ORDER gain on top of the input width.
  function automatic int unsigned acc_width(input int unsigned num_ch,
                                            input int unsigned decim,
                                            input int unsigned order);
    return in_width(num_ch) + order * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_cic_decimator.sv
// CIC decimator: per-strobe integrators, frame counter, comb chain and
// output register with valid/ready handshake and sticky overrun.
module pdm_cic_decimator
  import supermic_pkg::*;
#(
  parameter int unsigned IN_W      = in_width(DEF_NUM_CH),
  parameter int unsigned DECIM     = DEF_DECIM,
  parameter int unsigned CIC_ORDER = DEF_CIC_ORDER,
  parameter int unsigned ACC_W     = acc_width(DEF_NUM_CH, DEF_DECIM, DEF_CIC_ORDER),
  parameter int unsigned OUT_W     = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    strobe,
  input  logic signed [IN_W-1:0]  sample_in,
  output logic                    frame_wrap,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned CNT_W = $clog2(DECIM);

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] integ     [CIC_ORDER];
  logic signed [ACC_W-1:0] integ_nxt [CIC_ORDER];
  logic signed [ACC_W-1:0] comb_dly  [CIC_ORDER];
  logic signed [ACC_W-1:0] comb_in   [CIC_ORDER];
  logic signed [ACC_W-1:0] comb_out;
  logic                    comb_go;
  logic                    smp_go;
  logic signed [OUT_W-1:0] smp;

  assign frame_wrap = strobe && (cnt == CNT_W'(DECIM - 1));

  // Integrator cascade settles within the strobe cycle so the wrap strobe's
  // own input is included in the frame it closes.
  always_comb begin : integ_chain
    logic signed [ACC_W-1:0] run;
    integ_nxt = '{default: '0};
    run = {{(ACC_W-IN_W){sample_in[IN_W-1]}}, sample_in};
    for (int unsigned k = 0; k < CIC_ORDER; k++) begin
      run          = integ[k] + run;
      integ_nxt[k] = run;
    end
  end

  always_comb begin : comb_chain
    logic signed [ACC_W-1:0] run;
    comb_in = '{default: '0};
    run     = integ[CIC_ORDER-1];
    for (int unsigned k = 0; k < CIC_ORDER; k++) begin
      comb_in[k] = run;
      run        = run - comb_dly[k];
    end
    comb_out = run;
  end

  // Two-stage pipeline: comb at wrap+1, output register at wrap+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      integ     <= '{default: '0};
      comb_dly  <= '{default: '0};
      comb_go   <= 1'b0;
      smp_go    <= 1'b0;
      smp       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      comb_go <= frame_wrap;
      smp_go  <= comb_go;
      if (strobe) begin
        cnt   <= cnt + CNT_W'(1);
        integ <= integ_nxt;
      end
      if (comb_go) begin
        comb_dly <= comb_in;
        smp      <= comb_out[ACC_W-1 -: OUT_W];
      end
      if (smp_go) begin
        if (!out_valid || out_ready) begin
          out_data  <= smp;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pdm_das_decimator.sv
// Delay-and-sum beamformer over PDM microphones feeding a CIC decimator.
// Optional per-channel enable mask built when DAS_CH_MASK_EN is defined.
module pdm_das_decimator
  import supermic_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY,
  parameter int unsigned DECIM     = DEF_DECIM,
  parameter int unsigned CIC_ORDER = DEF_CIC_ORDER,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  localparam int unsigned DLY_W    = $clog2(MAX_DELAY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm_strobe,
  input  logic [NUM_CH-1:0]       pdm_in,
  input  logic [NUM_CH*DLY_W-1:0] ch_delay,
  input  logic                    cfg_load,
`ifdef DAS_CH_MASK_EN
  input  logic [NUM_CH-1:0]       ch_enable,
`endif
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned IN_W  = in_width(NUM_CH);
  localparam int unsigned ACC_W = acc_width(NUM_CH, DECIM, CIC_ORDER);

  logic [MAX_DELAY-1:0]    line [NUM_CH];
  logic [DLY_W-1:0]        wr_ptr;
  logic [NUM_CH*DLY_W-1:0] dly_pending;
  logic [NUM_CH*DLY_W-1:0] dly_active;
  logic [NUM_CH-1:0]       tap;
  logic [NUM_CH-1:0]       contrib_en;
  logic signed [IN_W-1:0]  sum;
  logic                    frame_wrap;

`ifdef DAS_CH_MASK_EN
  assign contrib_en = ch_enable;
`else
  assign contrib_en = '1;
`endif

  // Delay 0 bypasses the line so the current bit is used directly.
  always_comb begin
    logic [DLY_W-1:0] rd_addr;
    tap     = '0;
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_addr = wr_ptr - dly_active[i*DLY_W +: DLY_W];
      if (dly_active[i*DLY_W +: DLY_W] == '0) begin
        tap[i] = pdm_in[i];
      end else begin
        tap[i] = line[i][rd_addr];
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (contrib_en[i]) begin
        sum = tap[i] ? sum + IN_W'(1) : sum - IN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        line[i] <= '0;
      end
      wr_ptr      <= '0;
      dly_pending <= '0;
      dly_active  <= '0;
    end else begin
      if (pdm_strobe) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          line[i][wr_ptr] <= pdm_in[i];
        end
        wr_ptr <= wr_ptr + DLY_W'(1);
      end
      // Steering changes only at frame boundaries; the wrap strobe itself
      // still used the old delays above.
      if (frame_wrap) begin
        dly_active <= dly_pending;
      end
      if (cfg_load) begin
        dly_pending <= ch_delay;
      end
    end
  end

  pdm_cic_decimator #(
    .IN_W      (IN_W),
    .DECIM     (DECIM),
    .CIC_ORDER (CIC_ORDER),
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W)
  ) u_cic (
    .clk        (clk),
    .rst        (rst),
    .strobe     (pdm_strobe),
    .sample_in  (sum),
    .frame_wrap (frame_wrap),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

endmodule
